// File: rtl/zvc_pkg.sv
// Shared definitions for the zero-value decompressor: default geometry,
// FSM state encoding and the chunk popcount helper.
package zvc_pkg;

    localparam int unsigned WORD_WIDTH     = 8;
    localparam int unsigned LINE_SIZE      = 128;
    localparam int unsigned DIST_WIDTH     = 7;
    localparam int unsigned MAX_LIFM_RSIZ  = 4;
    localparam int unsigned CHUNK_SIZE     = 16;
    localparam int unsigned MT_ENTRY_WIDTH = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int unsigned PTR_WIDTH      = $clog2(LINE_SIZE) + 1;
    localparam int unsigned CNT_WIDTH      = $clog2(CHUNK_SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        HOLD
    } zvc_state_t;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [CHUNK_SIZE-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < CHUNK_SIZE; i++) begin
            n = n + CNT_WIDTH'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/zvc_chunk_expander.sv
// Combinational expansion of one chunk of dense positions from the packed
// nonzero words and MT entries, starting at read pointer base_ptr.
module zvc_chunk_expander
    import zvc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = zvc_pkg::WORD_WIDTH,
    parameter int unsigned LINE_SIZE     = zvc_pkg::LINE_SIZE,
    parameter int unsigned DIST_WIDTH    = zvc_pkg::DIST_WIDTH,
    parameter int unsigned MAX_LIFM_RSIZ = zvc_pkg::MAX_LIFM_RSIZ,
    parameter int unsigned CHUNK_SIZE    = zvc_pkg::CHUNK_SIZE
) (
    input  logic [CHUNK_SIZE-1:0]                          chunk_mask,
    input  logic [$clog2(LINE_SIZE):0]                     base_ptr,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]                lifm_packed,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]  mt_packed,
    output logic [CHUNK_SIZE*WORD_WIDTH-1:0]               lifm_chunk,
    output logic [CHUNK_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_chunk,
    output logic [$clog2(CHUNK_SIZE):0]                    chunk_pop
);

    localparam int unsigned PW   = $clog2(LINE_SIZE) + 1;
    localparam int unsigned MT_W = DIST_WIDTH * MAX_LIFM_RSIZ;

    logic [PW-1:0] offset;
    logic [PW-1:0] idx;

    // A set mask bit implies idx < LINE_SIZE, so the top pointer bit is never needed for selection.
    always_comb begin
        lifm_chunk = '0;
        mt_chunk   = '0;
        offset     = '0;
        idx        = '0;
        for (int unsigned j = 0; j < CHUNK_SIZE; j++) begin
            idx = base_ptr + offset;
            if (chunk_mask[j]) begin
                lifm_chunk[j*WORD_WIDTH +: WORD_WIDTH] = lifm_packed[idx[PW-2:0]*WORD_WIDTH +: WORD_WIDTH];
                mt_chunk[j*MT_W +: MT_W]               = mt_packed[idx[PW-2:0]*MT_W +: MT_W];
                offset = offset + PW'(1);
            end
        end
    end

    assign chunk_pop = popcount(chunk_mask);

endmodule

// File: rtl/zvc_decompressor.sv
// Zero-value decompressor: rebuilds dense LIFM and mapping-table lines one chunk per cycle.
// Optional consistency check enabled by defining ZVC_DECOMP_CHECK_EN.
module zvc_decompressor
    import zvc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = zvc_pkg::WORD_WIDTH,
    parameter int unsigned LINE_SIZE     = zvc_pkg::LINE_SIZE,
    parameter int unsigned DIST_WIDTH    = zvc_pkg::DIST_WIDTH,
    parameter int unsigned MAX_LIFM_RSIZ = zvc_pkg::MAX_LIFM_RSIZ,
    parameter int unsigned CHUNK_SIZE    = zvc_pkg::CHUNK_SIZE
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         comp_valid,
    output logic                                         comp_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_comp,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
    input  logic [LINE_SIZE-1:0]                          comp_mask,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_line,
    output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_line,
    output logic                                         dec_err
);

    localparam int unsigned NUM_CHUNKS = LINE_SIZE / CHUNK_SIZE;
    localparam int unsigned MT_W       = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int unsigned PW         = $clog2(LINE_SIZE) + 1;
    localparam int unsigned CW         = $clog2(CHUNK_SIZE) + 1;
    localparam int unsigned CHW        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    zvc_state_t state, next_state;

    logic [CHW-1:0]                  chunk;
    logic [PW-1:0]                   ptr;
    logic [LINE_SIZE-1:0]            mask_q;
    logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_q;
    logic [LINE_SIZE*MT_W-1:0]       mt_q;
    logic [CHUNK_SIZE-1:0]           chunk_mask;
    logic [CHUNK_SIZE*WORD_WIDTH-1:0] lifm_chunk;
    logic [CHUNK_SIZE*MT_W-1:0]      mt_chunk;
    logic [CW-1:0]                   chunk_pop;
    logic                            accept;
    logic                            last_chunk;

    assign chunk_mask = mask_q[chunk*CHUNK_SIZE +: CHUNK_SIZE];
    assign last_chunk = (chunk == CHW'(NUM_CHUNKS - 1));

    zvc_chunk_expander #(
        .WORD_WIDTH    (WORD_WIDTH),
        .LINE_SIZE     (LINE_SIZE),
        .DIST_WIDTH    (DIST_WIDTH),
        .MAX_LIFM_RSIZ (MAX_LIFM_RSIZ),
        .CHUNK_SIZE    (CHUNK_SIZE)
    ) u_expander (
        .chunk_mask  (chunk_mask),
        .base_ptr    (ptr),
        .lifm_packed (lifm_q),
        .mt_packed   (mt_q),
        .lifm_chunk  (lifm_chunk),
        .mt_chunk    (mt_chunk),
        .chunk_pop   (chunk_pop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        comp_ready = (state == IDLE);
        out_valid  = (state == HOLD);
        accept     = comp_valid && (state == IDLE);
        case (state)
            IDLE:    if (accept)     next_state = EXPAND;
            EXPAND:  if (last_chunk) next_state = HOLD;
            HOLD:    if (out_ready)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chunk     <= '0;
            ptr       <= '0;
            mask_q    <= '0;
            lifm_q    <= '0;
            mt_q      <= '0;
            lifm_line <= '0;
            mt_line   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mask_q    <= comp_mask;
                        lifm_q    <= lifm_comp;
                        mt_q      <= mt_comp;
                        lifm_line <= '0;
                        mt_line   <= '0;
                        chunk     <= '0;
                        ptr       <= '0;
                    end
                end
                EXPAND: begin
                    lifm_line[chunk*CHUNK_SIZE*WORD_WIDTH +: CHUNK_SIZE*WORD_WIDTH] <= lifm_chunk;
                    mt_line[chunk*CHUNK_SIZE*MT_W +: CHUNK_SIZE*MT_W]               <= mt_chunk;
                    ptr   <= ptr + PW'(chunk_pop);
                    chunk <= chunk + CHW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ZVC_DECOMP_CHECK_EN
    logic zero_hit;

    always_comb begin
        zero_hit = 1'b0;
        for (int unsigned j = 0; j < CHUNK_SIZE; j++) begin
            if (chunk_mask[j] && (lifm_chunk[j*WORD_WIDTH +: WORD_WIDTH] == '0)) zero_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          dec_err <= 1'b0;
        else if ((state == EXPAND) && zero_hit) dec_err <= 1'b1;
    end
`else
    assign dec_err = 1'b0;
`endif

endmodule
